puf_access_arbiter: RTL

- Shares one PUF core between two requesters: requester 0 is the JTAG PUF-auth path, requester 1 is the on-chip self-test/enrolment path.
- Arbitrates round-robin and drives the PUF challenge/generate handshake.
- Bounds the wait for puf_ready with a timeout, then launches the response counter and waits for count_done.
- Returns the captured response and status to the granted requester. Sits between the JTAG auth logic, the PUF core and the counter.

---
 rtl/puf_access_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/puf_access_arbiter.sv
// puf_access_arbiter
// Shares one PUF core between two requesters (0 = JTAG auth, 1 = on-chip
// self-test/enrolment). Round-robin arbitration, PUF challenge/generate
// handshake with a bounded wait for puf_ready, response-counter launch with a
// bounded wait for count_done, then a one-cycle done pulse to the owner.
//
// Ports
//   TCK, TRST_N            clock (posedge) and async active-low reset
//   req0/chal0, req1/chal1 level requests and their challenges
//   grant0/grant1          current owner of the PUF (mutually exclusive)
//   done0/done1            one-cycle completion pulses
//   resp_out               captured response (16'hDEAD on ready timeout)
//   timeout_flag           1 = last transaction aborted by a timeout
//   puf_challenge          challenge latched at grant, stable until next grant
//   puf_generate           one-cycle start pulse to the PUF core
//   puf_response/puf_ready PUF output and its valid level
//   counter_start          one-cycle launch pulse to the response counter
//   count_done             counter finished
//   busy                   arbiter is not idle
module puf_access_arbiter #(
  parameter int unsigned CHAL_W         = 5,
  parameter int unsigned RESP_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMR_W          = 8
) (
  input  logic              TCK,
  input  logic              TRST_N,
  input  logic              req0,
  input  logic [CHAL_W-1:0] chal0,
  input  logic              req1,
  input  logic [CHAL_W-1:0] chal1,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic [RESP_W-1:0] resp_out,
  output logic              timeout_flag,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_generate,
  input  logic [RESP_W-1:0] puf_response,
  input  logic              puf_ready,
  output logic              counter_start,
  input  logic              count_done,
  output logic              busy
);

  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ZERO   = '0;
  localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
  localparam logic [RESP_W-1:0] ABORT_RESP = RESP_W'(16'hDEAD);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_COUNT    = 3'd3,
    ST_RELEASE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                last_served_q, last_served_d;
  logic                grant0_q, grant0_d;
  logic                grant1_q, grant1_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic                timeout_q, timeout_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic                gen_q, gen_d;
  logic                cstart_q, cstart_d;
  logic                busy_q, busy_d;
  logic                pick0_c;
  logic                pick1_c;

  // Round-robin pick: on a tie, the requester not served last wins.
  assign pick0_c = req0 && (!req1 || last_served_q);
  assign pick1_c = req1 && !pick0_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    last_served_d = last_served_q;
    grant0_d      = grant0_q;
    grant1_d      = grant1_q;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    resp_d        = resp_q;
    timeout_d     = timeout_q;
    chal_d        = chal_q;
    gen_d         = 1'b0;
    cstart_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick0_c) begin
          grant0_d = 1'b1;
          chal_d   = chal0;
          state_d  = ST_ISSUE;
        end else if (pick1_c) begin
          grant1_d = 1'b1;
          chal_d   = chal1;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        gen_d     = 1'b1;
        timer_d   = TMR_ZERO;
        timeout_d = 1'b0;
        state_d   = ST_WAIT_RDY;
      end

      ST_WAIT_RDY: begin
        timer_d = timer_q + TMR_ONE;
        // First cycle is blanked so a ready left over from before is ignored.
        if (puf_ready && (timer_q != TMR_ZERO)) begin
          resp_d   = puf_response;
          cstart_d = 1'b1;
          timer_d  = TMR_ZERO;
          state_d  = ST_COUNT;
        end else if (timer_q == TMR_LAST) begin
          resp_d    = ABORT_RESP;
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end
      end

      ST_COUNT: begin
        timer_d = timer_q + TMR_ONE;
        if (count_done) begin
          state_d = ST_RELEASE;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        done0_d       = grant0_q;
        done1_d       = grant1_q;
        last_served_d = grant1_q;
        grant0_d      = 1'b0;
        grant1_d      = 1'b0;
        timer_d       = TMR_ZERO;
        state_d       = ST_IDLE;
      end

      default: begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        timer_d  = TMR_ZERO;
        state_d  = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      last_served_q <= 1'b1;
      grant0_q      <= 1'b0;
      grant1_q      <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      resp_q        <= '0;
      timeout_q     <= 1'b0;
      chal_q        <= '0;
      gen_q         <= 1'b0;
      cstart_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      last_served_q <= last_served_d;
      grant0_q      <= grant0_d;
      grant1_q      <= grant1_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      resp_q        <= resp_d;
      timeout_q     <= timeout_d;
      chal_q        <= chal_d;
      gen_q         <= gen_d;
      cstart_q      <= cstart_d;
      busy_q        <= busy_d;
    end
  end

  assign grant0        = grant0_q;
  assign grant1        = grant1_q;
  assign done0         = done0_q;
  assign done1         = done1_q;
  assign resp_out      = resp_q;
  assign timeout_flag  = timeout_q;
  assign puf_challenge = chal_q;
  assign puf_generate  = gen_q;
  assign counter_start = cstart_q;
  assign busy          = busy_q;

endmodule
